// File: rtl/bcd_xs3_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_xs3_pkg : shared types and constants for the BCD to excess-3 sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
package bcd_xs3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] XS3_OFFSET  = 4'd3;
  localparam logic [3:0] XS3_INVALID = 4'hF;
  localparam logic [3:0] BCD_MAX     = 4'd9;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_xs3.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_digit_xs3 : combinational single-digit BCD to excess-3 converter
// Revision      : 1.0
// ---------------------------------------------------------------------------
module bcd_digit_xs3
  import bcd_xs3_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] xs3_o,
  output logic       invalid_o
);

  always_comb begin
    invalid_o = (digit_i > BCD_MAX);
    xs3_o     = invalid_o ? XS3_INVALID : (digit_i + XS3_OFFSET);
  end

endmodule
`default_nettype wire

// File: rtl/bcd_xs3_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_xs3_seq_ctrl : converts a packed BCD word to excess-3, one digit/clock
// Revision         : 1.0
// ---------------------------------------------------------------------------
module bcd_xs3_seq_ctrl
  import bcd_xs3_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_bcd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_xs3,
  output logic [NDIG-1:0]   err_mask,
  output logic              out_err,
  output logic              busy
);

  localparam int            CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [4*NDIG-1:0]   word_q, word_d;
  logic [4*NDIG-1:0]   xs3_q, xs3_d;
  logic [NDIG-1:0]     mask_q, mask_d;
  logic                out_err_q, out_err_d;

  logic [3:0]          cur_digit;
  logic [3:0]          cur_xs3;
  logic                cur_invalid;

  // Single shared converter; the digit index selects its operand.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == CW'(i)) cur_digit = word_q[4*i +: 4];
    end
  end

  bcd_digit_xs3 u_digit (
    .digit_i   (cur_digit),
    .xs3_o     (cur_xs3),
    .invalid_o (cur_invalid)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    xs3_d     = xs3_q;
    mask_d    = mask_q;
    out_err_d = out_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_bcd;
          xs3_d   = '0;
          mask_d  = '0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < NDIG; i++) begin
          if (idx_q == CW'(i)) begin
            xs3_d[4*i +: 4] = cur_xs3;
            mask_d[i]       = cur_invalid;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d   = DONE;
          out_err_d = |mask_d;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d   = IDLE;
          out_err_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        out_err_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      word_q    <= '0;
      xs3_q     <= '0;
      mask_q    <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      xs3_q     <= xs3_d;
      mask_q    <= mask_d;
      out_err_q <= out_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CONV) || (state_q == DONE);
  assign out_valid = (state_q == DONE);
  assign out_xs3   = xs3_q;
  assign err_mask  = mask_q;
  assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_xs3_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bcd_xs3_seq_ctrl : directed + random bench for NDIG=4 and NDIG=1 builds
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_bcd_xs3_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // NDIG=4 instance
  logic        a_rst_n = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [15:0] a_in_bcd = '0;
  logic        a_in_ready, a_out_valid, a_out_err, a_busy;
  logic [15:0] a_out_xs3;
  logic [3:0]  a_err_mask;

  // NDIG=1 instance
  logic        b_rst_n = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [3:0]  b_in_bcd = '0;
  logic        b_in_ready, b_out_valid, b_out_err, b_busy;
  logic [3:0]  b_out_xs3;
  logic [0:0]  b_err_mask;

  int checks = 0;
  int failures = 0;

  bcd_xs3_seq_ctrl #(.NDIG(4)) u_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_bcd(a_in_bcd), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_xs3(a_out_xs3), .err_mask(a_err_mask), .out_err(a_out_err), .busy(a_busy)
  );

  bcd_xs3_seq_ctrl #(.NDIG(1)) u_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_bcd(b_in_bcd), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_xs3(b_out_xs3), .err_mask(b_err_mask), .out_err(b_out_err), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each nibble is an independent decimal digit; >9 is an error.
  task automatic model(input logic [15:0] w, input int nd,
                       output logic [15:0] xs3, output logic [3:0] mask);
    int d;
    xs3 = '0;
    mask = '0;
    for (int i = 0; i < nd; i++) begin
      d = (w >> (4 * i)) % 16;
      if (d <= 9) xs3 = xs3 | 16'((d + 3) << (4 * i));
      else begin
        xs3 = xs3 | 16'(15 << (4 * i));
        mask[i] = 1'b1;
      end
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic xact_a(input logic [15:0] bcd, input int stall, input bit poke);
    logic [15:0] ex;
    logic [3:0]  em;
    int n;
    model(bcd, 4, ex, em);
    n = 0;
    while (!a_in_ready && n < 50) begin step(); n++; end
    chk("a_ready_wait", a_in_ready, 1);
    a_in_valid = 1'b1;
    a_in_bcd = bcd;
    a_out_ready = (stall == 0);
    step();
    a_in_valid = 1'b0;
    a_in_bcd = 16'($urandom);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("a_lat_valid", a_out_valid, (k == 4));
      chk("a_busy", a_busy, 1);
      chk("a_in_ready_busy", a_in_ready, 0);
    end
    chk("a_xs3", a_out_xs3, ex);
    chk("a_mask", a_err_mask, em);
    chk("a_err", a_out_err, (em != 0));
    for (int s = 0; s < stall; s++) begin
      if (poke) begin a_in_valid = 1'b1; a_in_bcd = 16'h0555; end
      step();
      chk("a_stall_valid", a_out_valid, 1);
      chk("a_stall_xs3", a_out_xs3, ex);
      chk("a_stall_mask", a_err_mask, em);
      chk("a_stall_ready", a_in_ready, 0);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    if (stall != 0) step();
    step();
    chk("a_post_valid", a_out_valid, 0);
    chk("a_post_ready", a_in_ready, 1);
    chk("a_post_busy", a_busy, 0);
    chk("a_post_err", a_out_err, 0);
    chk("a_post_hold", a_out_xs3, ex);
  endtask

  task automatic xact_b(input logic [3:0] d);
    logic [15:0] ex;
    logic [3:0]  em;
    model({12'd0, d}, 1, ex, em);
    chk("b_ready", b_in_ready, 1);
    b_in_valid = 1'b1;
    b_in_bcd = d;
    step();
    b_in_valid = 1'b0;
    step();
    chk("b_valid", b_out_valid, 1);
    chk("b_xs3", b_out_xs3, ex);
    chk("b_err", b_out_err, em[0]);
    chk("b_mask", b_err_mask, em[0]);
    step();
    chk("b_done", b_out_valid, 0);
  endtask

  initial begin
    bit stale;
    step();
    step();
    chk("rst_ready", a_in_ready, 1);
    chk("rst_valid", a_out_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_xs3", a_out_xs3, 0);
    chk("rst_mask", a_err_mask, 0);
    chk("rst_err", a_out_err, 0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    step();
    chk("rst_rel_ready", a_in_ready, 1);

    xact_a(16'h0129, 0, 1'b0);
    xact_a(16'h0000, 0, 1'b0);
    xact_a(16'h9999, 0, 1'b0);
    xact_a(16'h12A4, 0, 1'b0);
    xact_a(16'h0129, 5, 1'b1);
    xact_a(16'h0555, 0, 1'b0);

    // Abort mid-conversion
    a_in_valid = 1'b1;
    a_in_bcd = 16'h4321;
    a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    step();
    step();
    a_rst_n = 1'b0;
    step();
    chk("abort_valid", a_out_valid, 0);
    chk("abort_xs3", a_out_xs3, 0);
    chk("abort_busy", a_busy, 0);
    chk("abort_ready", a_in_ready, 1);
    a_rst_n = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (a_out_valid || !a_in_ready) stale = 1'b1;
    end
    chk("abort_no_stale", stale, 0);

    for (int r = 0; r < 20; r++) begin
      logic [15:0] w;
      for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(0, 12));
      xact_a(w, int'($urandom_range(0, 3)), 1'b0);
    end

    for (int d = 0; d < 16; d++) xact_b(4'(d));
    for (int r = 0; r < 8; r++) xact_b(4'($urandom_range(0, 15)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_xs3_seq_ctrl.md
Name: bcd_xs3_seq_ctrl

Overview:
Sequencing controller that converts a packed multi-digit BCD word to excess-3 one digit per clock, reusing a single shared digit converter. It accepts a word over a valid/ready input handshake and walks the digits LSB-first. It flags any non-BCD nibble and presents the packed result over a valid/ready output handshake. It sits between a BCD source (counter/display logic) and excess-3 consumers.

Parameters:
NDIG, 4, number of BCD digits per word (>=1)
CW, $clog2(NDIG) (min 1), digit-index counter width (derived, localparam)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  source presents in_bcd
in_ready  output  1  controller can accept a word
in_bcd  input  4*NDIG  packed BCD word, digit i = bits [4i+3:4i]
out_valid  output  1  out_xs3/out_err/err_mask valid
out_ready  input  1  consumer accepts result
out_xs3  output  4*NDIG  packed excess-3 result
err_mask  output  NDIG  bit i set if input digit i > 9
out_err  output  1  OR of err_mask
busy  output  1  high in CONV or DONE

Behaviour:
- Interface: one clock; reset is synchronous and active-low; clock port clk, reset port rst_n.
- Reset (rst_n=0 at a rising edge): state=IDLE; idx=0; captured word, out_xs3, err_mask, out_err=0; out_valid=0; busy=0; in_ready=1 from the first cycle after reset.
- Reset mid-operation aborts the word in flight. No output is produced for it.
- State IDLE:
  - in_ready=1, busy=0.
  - On in_valid&in_ready: capture in_bcd, clear out_xs3/err_mask, idx=0, go to CONV.
- State CONV:
  - in_ready=0, busy=1.
  - Each cycle, digit idx of the captured word is fed to the shared converter.
  - Result is written to out_xs3 nibble idx; err_mask[idx] is set to the converter's invalid flag.
  - idx increments each cycle.
  - When idx==NDIG-1 this cycle, go to DONE; idx does not wrap inside CONV.
- State DONE:
  - out_valid=1, busy=1, in_ready=0.
  - out_xs3, err_mask and out_err are held stable while out_ready=0, for any number of cycles.
  - On out_ready: go to IDLE and drop out_valid next cycle.
  - No accept occurs in the same cycle as out_ready; minimum spacing between accepts is NDIG+2 cycles.
- Latency: with the accept at edge t, out_valid is high in the cycle following edge t+NDIG.
- Digit conversion: valid digit (0-9) gives digit+3, 4-bit result, no overflow. Digit 10-15 gives 4'hF and the invalid flag.
- in_valid while not in IDLE is ignored; the source must hold it until in_ready.
- out_err is registered and equals |err_mask whenever out_valid=1. It is 0 otherwise.
- Output registers keep the last result after the DONE->IDLE transition. They are meaningful only while out_valid=1.

Decomposition:
- Package bcd_xs3_pkg holds:
  - state enum {IDLE, CONV, DONE}, 2 bits;
  - XS3_OFFSET=4'd3;
  - XS3_INVALID=4'hF;
  - BCD_MAX=4'd9.
- One sub-module, bcd_digit_xs3: purely combinational. Input 4-bit digit; outputs 4-bit xs3 and 1-bit invalid.
- The controller instantiates exactly one bcd_digit_xs3, which is the shared resource.

Test Plan:
- NDIG=4, in_bcd=16'h0129, out_ready=1 -> out_xs3=16'h345C, err_mask=4'b0000, out_err=0, out_valid first high 4 cycles after the accept edge, for 1 cycle.
- in_bcd=16'h0000 then 16'h9999 back-to-back -> 16'h3333 then 16'hCCCC. in_ready is low during CONV/DONE; the second word is accepted only after return to IDLE.
- in_bcd=16'h12A4 -> out_xs3=16'h45F7, err_mask=4'b0010, out_err=1.
- Backpressure: result 16'h345C with out_ready=0 for 5 cycles -> out_valid, out_xs3 and err_mask stable all 5 cycles. A new in_valid with 16'h0555 during the stall is not accepted. After out_ready=1, the next word gives 16'h3888.
- Reset mid-CONV: accept 16'h4321, assert rst_n=0 after 2 CONV cycles -> next edge gives state IDLE, out_valid=0, out_xs3=0, busy=0. After release, in_ready=1 and no stale result ever appears.
- All digits via NDIG=1: in_bcd=0..15 -> out_xs3=3..12 with out_err=0 for 0-9; 4'hF with out_err=1 for 10-15; latency 1 cycle.
